// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle unsigned MUL/DIV unit with its sequencer
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic              mode,
  input  logic [XLEN-1:0]   in_A,
  input  logic [XLEN-1:0]   in_B,
  output logic              busy,
  output logic              ready,
  output logic [2*XLEN-1:0] out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_OUT} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [XLEN-1:0]     r_b;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN:0]       r_rem;
  logic [XLEN-1:0]     r_quo;
  logic [2*XLEN-1:0]   r_out;

  logic                w_last;
  logic [XLEN:0]       w_sum;
  logic [2*XLEN-1:0]   w_acc_next;
  logic [XLEN+1:0]     w_rem_sh;
  logic [XLEN+1:0]     w_t;
  logic                w_take;
  logic [XLEN:0]       w_rem_next;
  logic [XLEN-1:0]     w_quo_next;

  assign w_last = (r_cnt == CNT_W'(XLEN - 1));

  // Shift-add step: conditional add of B into the upper half, then shift
  // the carry-extended accumulator right by one.
  assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : {(XLEN+1){1'b0}});
  assign w_acc_next = {w_sum, r_acc[XLEN-1:1]};

  // Restoring-divide step: shift the next dividend bit into rem, trial
  // subtract B, keep the difference only when it did not go negative.
  // The extra top bit on the trial subtraction makes its sign unambiguous.
  assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
  assign w_t        = w_rem_sh - {2'b00, r_b};
  assign w_take     = ~w_t[XLEN+1];
  assign w_rem_next = w_take ? w_t[XLEN:0] : w_rem_sh[XLEN:0];
  assign w_quo_next = {r_quo[XLEN-2:0], w_take};

  assign out = r_out;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: the state itself remembers the latched mode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (valid) w_next = mode ? S_DIV : S_MUL;
      S_MUL:   if (w_last) w_next = S_OUT;
      S_DIV:   if (w_last) w_next = S_OUT;
      S_OUT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from the current state.
  always_comb begin
    busy  = (r_state != S_IDLE);
    ready = (r_state == S_OUT);
  end

  // Datapath: operand capture in IDLE, one iteration per cycle while
  // working; the final result is captured on the last iteration so it is
  // valid during OUT and holds afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_rem <= '0;
      r_quo <= '0;
      r_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (valid) begin
            r_b   <= in_B;
            r_acc <= {{XLEN{1'b0}}, in_A};
            r_rem <= '0;
            r_quo <= in_A;
            r_cnt <= '0;
          end
        end
        S_MUL: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_out <= w_acc_next;
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_out <= {w_rem_next[XLEN-1:0], w_quo_next};
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        mode;
  logic [31:0] in_A;
  logic [31:0] in_B;
  logic        busy;
  logic        ready;
  logic [63:0] out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycles left in the current op (0 = idle),
  // result pending for the op in flight, and the value out must show.
  int          m_left = 0;
  logic [63:0] m_pend = '0;
  logic [63:0] m_out  = '0;

  muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .valid (valid),
    .mode  (mode),
    .in_A  (in_A),
    .in_B  (in_B),
    .busy  (busy),
    .ready (ready),
    .out   (out)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_res(input logic m, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a64;
    logic [63:0] b64;
    a64 = {32'b0, a};
    b64 = {32'b0, b};
    if (!m)          return a64 * b64;
    else if (b == 0) return {a, 32'hFFFF_FFFF};
    else             return {a % b, a / b};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timing model: accepted op is busy for 33 cycles, result shows in the last.
  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_out  <= '0;
    end else if (m_left == 0) begin
      if (valid) begin
        m_left <= 33;
        m_pend <= ref_res(mode, in_A, in_B);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) m_out <= m_pend;
    end
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("busy", {63'b0, busy}, {63'b0, (m_left != 0)});
    chk("ready", {63'b0, ready}, {63'b0, (m_left == 1)});
    if (m_left <= 1) chk("out", out, m_out);
  end

  task automatic start(input logic m, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    valid = 1'b1; mode = m; in_A = a; in_B = b;
    @(posedge clk); #1;
    valid = 1'b0; in_A = $urandom; in_B = $urandom; mode = $urandom_range(0, 1);
  endtask

  task automatic wait_ready(input string name, input logic [63:0] exp);
    int lat;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ready) begin
        lat = i;
        break;
      end
      in_A = $urandom; in_B = $urandom;
    end
    chk({name, "_latency"}, 64'(lat), 64'd33);
    chk({name, "_out"}, out, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rdy;
    rst = 1'b1; valid = 1'b1; mode = 1'b0; in_A = 32'd1; in_B = 32'd1;

    // Model pinned to hand-computed values.
    chk("model_mul_small", ref_res(1'b0, 32'd3, 32'd5), 64'h0000_0000_0000_000F);
    chk("model_div_zero", ref_res(1'b1, 32'h1234, 32'd0), {32'h0000_1234, 32'hFFFF_FFFF});

    // Reset held with valid high: request must be dropped.
    repeat (3) @(posedge clk);
    #1; rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_ready", {63'b0, ready}, 64'd0);
    chk("reset_out", out, 64'd0);

    start(1'b0, 32'd3, 32'd5);
    wait_ready("mul_3x5", 64'h0000_0000_0000_000F);
    start(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_ready("mul_max", 64'hFFFF_FFFE_0000_0001);
    start(1'b1, 32'd100, 32'd7);
    wait_ready("div_100_7", {32'd2, 32'd14});
    start(1'b1, 32'd7, 32'd100);
    wait_ready("div_7_100", {32'd7, 32'd0});
    start(1'b1, 32'h0000_1234, 32'd0);
    wait_ready("div_by_zero", {32'h0000_1234, 32'hFFFF_FFFF});

    // valid pulse while busy is ignored.
    start(1'b0, 32'd6, 32'd7);
    for (int i = 1; i <= 33; i++) begin
      @(negedge clk);
      if (i == 4) begin valid = 1'b1; mode = 1'b1; in_A = 32'd9; in_B = 32'd3; end
      if (i == 5) begin valid = 1'b0; in_A = $urandom; in_B = $urandom; end
      if (i < 33) chk("busy_no_early_ready", {63'b0, ready}, 64'd0);
    end
    chk("busy_ignore_ready", {63'b0, ready}, 64'd1);
    chk("busy_ignore_out", out, 64'd42);
    // Next IDLE cycle accepts a new op.
    start(1'b1, 32'd100, 32'd7);
    wait_ready("back_to_back", {32'd2, 32'd14});
    @(negedge clk);
    chk("out_holds_idle", out, {32'd2, 32'd14});

    // Reset mid-DIV, with valid asserted alongside it.
    start(1'b1, 32'd100, 32'd7);
    for (int i = 1; i <= 10; i++) @(negedge clk);
    rst = 1'b1; valid = 1'b1; mode = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    chk("abort_out", out, 64'd0);
    n_rdy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) n_rdy++;
    end
    chk("abort_no_ready", 64'(n_rdy), 64'd0);
    start(1'b0, 32'd2, 32'd3);
    wait_ready("after_abort", 64'd6);

    // Randomized traffic: valid mostly high, occasional reset.
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      valid = ($urandom_range(0, 3) != 0);
      mode  = $urandom_range(0, 1);
      in_A  = pick();
      in_B  = pick();
      rst   = ($urandom_range(0, 499) == 0);
    end
    @(posedge clk); #1;
    valid = 1'b0; rst = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
